// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg
// Configurable UART receiver: 5-9 data bits, optional even/odd parity,
// 1 or 2 stop bits. Each bit is a 3-point majority vote around mid-bit.
// Received words are presented through a held valid/ready output register
// carrying parity, framing and overrun status.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   rx         in   asynchronous serial input, idle high
//   ready      in   consumer accepts the held word when valid && ready
//   valid      out  held word available
//   data       out  received word, LSB = first bit on the line
//   parity_err out  parity mismatch for the held word (0 when PARITY = 0)
//   frame_err  out  a stop bit was sampled low for the held word
//   overrun    out  held word replaced an unaccepted previous word
//   busy       out  receiver FSM not idle (registered)
module uart_rx_cfg #(
   parameter int CPB       = 434,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   input  logic                 ready,
   output logic                 valid,
   output logic [DATA_BITS-1:0] data,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CW = $clog2(CPB);
   localparam int BW = $clog2(DATA_BITS);
   localparam int M  = CPB / 2;

   localparam logic [CW-1:0] C_S0   = CW'(M - 1);
   localparam logic [CW-1:0] C_S1   = CW'(M);
   localparam logic [CW-1:0] C_DEC  = CW'(M + 1);
   localparam logic [CW-1:0] C_LAST = CW'(CPB - 1);
   localparam logic [BW-1:0] C_LAST_BIT = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   // Expected parity bit: XOR of the data for even, inverted for odd.
   function automatic logic f_parity_exp(input logic [DATA_BITS-1:0] d);
      return (^d) ^ (PARITY == 2);
   endfunction

   // 2-of-3 majority vote.
   function automatic logic f_maj(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   state_t               r_state;
   logic                 r_rx_meta;
   logic                 r_rxs;
   logic [CW-1:0]        r_cnt;
   logic [BW-1:0]        r_bit_idx;
   logic                 r_stop_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_s0;
   logic                 r_s1;
   logic                 r_perr;
   logic                 r_ferr;
   logic                 r_armed;
   logic                 r_valid;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_parity_err;
   logic                 r_frame_err;
   logic                 r_overrun;
   logic                 r_busy;

   logic w_maj;
   logic w_dec;
   logic w_end;
   logic w_last_stop;

   // The third sample is the live synchronised input at the decision point.
   assign w_maj       = f_maj(r_s0, r_s1, r_rxs);
   assign w_dec       = (r_cnt == C_DEC);
   assign w_end       = (r_cnt == C_LAST);
   assign w_last_stop = (STOP_BITS == 1) || r_stop_idx;

   assign valid      = r_valid;
   assign data       = r_data;
   assign parity_err = r_parity_err;
   assign frame_err  = r_frame_err;
   assign overrun    = r_overrun;
   assign busy       = r_busy;

   // Two-flop synchroniser for the asynchronous line, reset to idle level.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_meta <= 1'b1;
         r_rxs     <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rxs     <= r_rx_meta;
      end
   end

   // First two majority samples, taken just before mid-bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s0 <= 1'b1;
         r_s1 <= 1'b1;
      end else begin
         if (r_cnt == C_S0) begin
            r_s0 <= r_rxs;
         end
         if (r_cnt == C_S1) begin
            r_s1 <= r_rxs;
         end
      end
   end

   // Receive FSM, bit counter and held output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_bit_idx    <= '0;
         r_stop_idx   <= 1'b0;
         r_shift      <= '0;
         r_perr       <= 1'b0;
         r_ferr       <= 1'b0;
         r_armed      <= 1'b0;
         r_valid      <= 1'b0;
         r_data       <= '0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
         r_overrun    <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_busy <= (r_state != S_IDLE);
         r_cnt  <= w_end ? '0 : r_cnt + CW'(1);

         // Acceptance; a commit later in this block overrides it.
         if (r_valid && ready) begin
            r_valid <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               // After a commit the line must be seen high before a new
               // start bit is accepted, so a held break yields one word.
               if (r_rxs) begin
                  r_armed <= 1'b1;
               end else if (r_armed) begin
                  r_state <= S_START;
                  r_perr  <= 1'b0;
                  r_ferr  <= 1'b0;
               end
            end
            S_START: begin
               if (w_dec && w_maj) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end else if (w_end) begin
                  r_state   <= S_DATA;
                  r_bit_idx <= '0;
               end
            end
            S_DATA: begin
               if (w_dec) begin
                  r_shift[r_bit_idx] <= w_maj;
               end
               if (w_end) begin
                  if (r_bit_idx == C_LAST_BIT) begin
                     r_bit_idx  <= '0;
                     r_stop_idx <= 1'b0;
                     r_state    <= (PARITY != 0) ? S_PARITY : S_STOP;
                  end else begin
                     r_bit_idx <= r_bit_idx + BW'(1);
                  end
               end
            end
            S_PARITY: begin
               if (w_dec) begin
                  r_perr <= (w_maj != f_parity_exp(r_shift));
               end
               if (w_end) begin
                  r_state    <= S_STOP;
                  r_stop_idx <= 1'b0;
               end
            end
            S_STOP: begin
               if (w_dec) begin
                  if (!w_maj) begin
                     r_ferr <= 1'b1;
                  end
                  // Leave at mid-bit of the last stop bit and commit.
                  if (w_last_stop) begin
                     r_state      <= S_IDLE;
                     r_cnt        <= '0;
                     r_armed      <= 1'b0;
                     r_data       <= r_shift;
                     r_parity_err <= (PARITY != 0) && r_perr;
                     r_frame_err  <= r_ferr | ~w_maj;
                     r_overrun    <= r_valid && !ready;
                     r_valid      <= 1'b1;
                  end
               end
               if (w_end) begin
                  r_stop_idx <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_cfg.sv
module tb_uart_rx_cfg;

   localparam int CPB0 = 434;
   localparam int CPB1 = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] rx_v = 3'b111;
   logic [2:0] rdy_v = 3'b111;

   logic       valid0, valid1, valid2;
   logic [7:0] data0, data1;
   logic [8:0] data2;
   logic       pe0, pe1, pe2, fe0, fe1, fe2, ov0, ov1, ov2, busy0, busy1, busy2;

   // unit 0: default 8N1 at CPB 434
   uart_rx_cfg dut0 (
      .clk(clk), .rst(rst), .rx(rx_v[0]), .ready(rdy_v[0]), .valid(valid0), .data(data0),
      .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .busy(busy0)
   );
   // unit 1: 8 bits, even parity, 1 stop
   uart_rx_cfg #(.CPB(CPB1), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut1 (
      .clk(clk), .rst(rst), .rx(rx_v[1]), .ready(rdy_v[1]), .valid(valid1), .data(data1),
      .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .busy(busy1)
   );
   // unit 2: 9 bits, odd parity, 2 stop
   uart_rx_cfg #(.CPB(CPB1), .DATA_BITS(9), .PARITY(2), .STOP_BITS(2)) dut2 (
      .clk(clk), .rst(rst), .rx(rx_v[2]), .ready(rdy_v[2]), .valid(valid2), .data(data2),
      .parity_err(pe2), .frame_err(fe2), .overrun(ov2), .busy(busy2)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // capture of every valid rise per unit
   int       vcnt[3];
   int       rise_t[3];
   logic [8:0] cap_d[3];
   logic     cap_pe[3], cap_fe[3], cap_ov[3];
   logic     pv[3];

   initial begin
      for (int i = 0; i < 3; i++) begin
         vcnt[i] = 0; rise_t[i] = 0; cap_d[i] = 9'h000;
         cap_pe[i] = 1'b0; cap_fe[i] = 1'b0; cap_ov[i] = 1'b0; pv[i] = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (valid0) begin
         vcnt[0]++;
         if (!pv[0]) begin
            rise_t[0] = cyc; cap_d[0] = {1'b0, data0};
            cap_pe[0] = pe0; cap_fe[0] = fe0; cap_ov[0] = ov0;
         end
      end
      if (valid1) begin
         vcnt[1]++;
         if (!pv[1]) begin
            rise_t[1] = cyc; cap_d[1] = {1'b0, data1};
            cap_pe[1] = pe1; cap_fe[1] = fe1; cap_ov[1] = ov1;
         end
      end
      if (valid2) begin
         vcnt[2]++;
         if (!pv[2]) begin
            rise_t[2] = cyc; cap_d[2] = data2;
            cap_pe[2] = pe2; cap_fe[2] = fe2; cap_ov[2] = ov2;
         end
      end
      pv[0] = valid0; pv[1] = valid1; pv[2] = valid2;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic bit_out(input int u, input logic b, input int cpb);
      rx_v[u] = b;
      repeat (cpb) @(negedge clk);
   endtask

   // Called at a negedge; the start bit falls immediately.
   task automatic send_frame(input int u, input logic [8:0] d, input int nb, input int cpb,
                             input bit has_par, input logic pb, input int nstop,
                             input logic s1, input logic s2);
      bit_out(u, 1'b0, cpb);
      for (int i = 0; i < nb; i++) bit_out(u, d[i], cpb);
      if (has_par) bit_out(u, pb, cpb);
      bit_out(u, s1, cpb);
      if (nstop == 2) bit_out(u, s2, cpb);
      rx_v[u] = 1'b1;
   endtask

   typedef struct {
      int         unit;
      logic [8:0] d;
      logic       pb;
      logic       s1;
      logic       s2;
      logic [8:0] exp_d;
      logic       exp_pe;
      logic       exp_fe;
      string      name;
   } vec_t;

   vec_t vt[9];

   int n0;
   int v0;
   int lat;

   initial begin
      // unit 1: even parity (expected bit = XOR of data)
      vt[0] = '{1, 9'h003, 1'b1, 1'b1, 1'b1, 9'h003, 1'b1, 1'b0, "e03_badpar"};
      vt[1] = '{1, 9'h003, 1'b0, 1'b1, 1'b1, 9'h003, 1'b0, 1'b0, "e03_okpar"};
      vt[2] = '{1, 9'h055, 1'b0, 1'b0, 1'b1, 9'h055, 1'b0, 1'b1, "e55_stop0"};
      vt[3] = '{1, 9'h007, 1'b1, 1'b1, 1'b1, 9'h007, 1'b0, 1'b0, "e07_okpar"};
      vt[4] = '{1, 9'h0FE, 1'b0, 1'b1, 1'b1, 9'h0FE, 1'b1, 1'b0, "eFE_badpar"};
      // unit 2: 9 bits odd parity (expected bit = inverted XOR), 2 stops
      vt[5] = '{2, 9'h1FF, 1'b0, 1'b1, 1'b1, 9'h1FF, 1'b0, 1'b0, "o1FF_ok"};
      vt[6] = '{2, 9'h1FF, 1'b0, 1'b1, 1'b0, 9'h1FF, 1'b0, 1'b1, "o1FF_stop2low"};
      vt[7] = '{2, 9'h0AA, 1'b0, 1'b1, 1'b1, 9'h0AA, 1'b1, 1'b0, "oAA_badpar"};
      vt[8] = '{2, 9'h101, 1'b1, 1'b0, 1'b1, 9'h101, 1'b0, 1'b1, "o101_stop1low"};

      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // reset state
      chk("rst_valid", {31'd0, valid0}, 32'd0);
      chk("rst_data", {24'd0, data0}, 32'd0);
      chk("rst_flags", {29'd0, pe0, fe0, ov0}, 32'd0);
      chk("rst_busy", {31'd0, busy0}, 32'd0);
      chk("rst_data2", {23'd0, data2}, 32'd0);
      repeat (4) @(negedge clk);

      // 1. default 8N1, 0xA5
      v0 = vcnt[0];
      n0 = cyc;
      send_frame(0, 9'h0A5, 8, CPB0, 1'b0, 1'b0, 1, 1'b1, 1'b1);
      repeat (20) @(negedge clk);
      chk("t1_vcycles", vcnt[0] - v0, 32'd1);
      chk("t1_data", {23'd0, cap_d[0]}, 32'h0A5);
      chk("t1_flags", {29'd0, cap_pe[0], cap_fe[0], cap_ov[0]}, 32'd0);
      // 3 + (1+8+0+1-1)*434 + 217 + 2 = 4128
      lat = rise_t[0] - n0;
      if (lat < 4127 || lat > 4129) chk("t1_latency", lat, 32'd4128);
      else chk("t1_latency", 32'd1, 32'd1 + 32'(lat < 4127 || lat > 4129));

      // 2. glitch rejection
      v0 = vcnt[0];
      rx_v[0] = 1'b0;
      repeat (50) @(negedge clk);
      chk("t2_busy_hi", {31'd0, busy0}, 32'd1);
      repeat (50) @(negedge clk);
      rx_v[0] = 1'b1;
      repeat (CPB0) @(negedge clk);
      chk("t2_busy_lo", {31'd0, busy0}, 32'd0);
      chk("t2_novalid", vcnt[0] - v0, 32'd0);

      // 3 and 5. parity / framing / 9-bit table
      for (int i = 0; i < 9; i++) begin
         int u;
         u = vt[i].unit;
         v0 = vcnt[u];
         send_frame(u, vt[i].d, (u == 2) ? 9 : 8, CPB1, 1'b1, vt[i].pb,
                    (u == 2) ? 2 : 1, vt[i].s1, vt[i].s2);
         repeat (2 * CPB1) @(negedge clk);
         chk({vt[i].name, "_cnt"}, vcnt[u] - v0, 32'd1);
         chk({vt[i].name, "_data"}, {23'd0, cap_d[u]}, {23'd0, vt[i].exp_d});
         chk({vt[i].name, "_perr"}, {31'd0, cap_pe[u]}, {31'd0, vt[i].exp_pe});
         chk({vt[i].name, "_ferr"}, {31'd0, cap_fe[u]}, {31'd0, vt[i].exp_fe});
         chk({vt[i].name, "_ovr"}, {31'd0, cap_ov[u]}, 32'd0);
      end

      // 4a. overrun with ready held low
      rdy_v[0] = 1'b0;
      send_frame(0, 9'h011, 8, CPB0, 1'b0, 1'b0, 1, 1'b1, 1'b1);
      chk("t4_first_valid", {31'd0, valid0}, 32'd1);
      chk("t4_first_data", {24'd0, data0}, 32'h11);
      chk("t4_first_ovr", {31'd0, ov0}, 32'd0);
      send_frame(0, 9'h022, 8, CPB0, 1'b0, 1'b0, 1, 1'b1, 1'b1);
      chk("t4_second_data", {24'd0, data0}, 32'h22);
      chk("t4_second_ovr", {31'd0, ov0}, 32'd1);
      rdy_v[0] = 1'b1;
      @(negedge clk);
      rdy_v[0] = 1'b0;
      @(negedge clk);
      chk("t4_accept_clears", {31'd0, valid0}, 32'd0);
      chk("t4_data_holds", {24'd0, data0}, 32'h22);

      // 4b. ready pulsed exactly in the commit cycle
      send_frame(0, 9'h033, 8, CPB0, 1'b0, 1'b0, 1, 1'b1, 1'b1);
      chk("t4b_held", {31'd0, valid0}, 32'd1);
      n0 = cyc;
      fork
         send_frame(0, 9'h044, 8, CPB0, 1'b0, 1'b0, 1, 1'b1, 1'b1);
         begin
            // commit edge is n0 + 4128; ready must be high across it
            while (cyc < n0 + 4127) @(negedge clk);
            rdy_v[0] = 1'b1;
            @(negedge clk);
            rdy_v[0] = 1'b0;
         end
      join
      chk("t4b_valid", {31'd0, valid0}, 32'd1);
      chk("t4b_data", {24'd0, data0}, 32'h44);
      chk("t4b_ovr", {31'd0, ov0}, 32'd0);
      rdy_v[0] = 1'b1;
      repeat (4) @(negedge clk);

      // 6. reset during data bit 4
      v0 = vcnt[0];
      rx_v[0] = 1'b0;
      repeat (CPB0) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx_v[0] = (i[0] == 1'b0) ? 1'b1 : 1'b0;
         repeat (CPB0) @(negedge clk);
      end
      rx_v[0] = 1'b0;
      repeat (CPB0 / 2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_rst_valid", {31'd0, valid0}, 32'd0);
      chk("t6_rst_busy", {31'd0, busy0}, 32'd0);
      chk("t6_rst_data", {24'd0, data0}, 32'd0);
      chk("t6_rst_flags", {29'd0, pe0, fe0, ov0}, 32'd0);
      rst = 1'b0;
      rx_v[0] = 1'b1;
      repeat (2 * CPB0) @(negedge clk);
      chk("t6_novalid", vcnt[0] - v0, 32'd0);
      send_frame(0, 9'h05A, 8, CPB0, 1'b0, 1'b0, 1, 1'b1, 1'b1);
      repeat (20) @(negedge clk);
      chk("t6_cnt", vcnt[0] - v0, 32'd1);
      chk("t6_data", {23'd0, cap_d[0]}, 32'h05A);
      chk("t6_flags", {29'd0, cap_pe[0], cap_fe[0], cap_ov[0]}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
